// File: rtl/crossing_gate_sequencer.sv
// Level-crossing gate sequencer: a Moore FSM that runs warning, lowering, clear-delay and raising
// from the track occupancy flags, and supervises the limit switches with a movement timeout.
`timescale 1ns/1ps
module crossing_gate_sequencer #(
    parameter int WARN_CYC  = 8,
    parameter int CLEAR_CYC = 4,
    parameter int MOVE_TMO  = 16,
    parameter int TW        = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] occ,
    input  logic       limit_closed,
    input  logic       limit_open,
    input  logic       fault_clr,
    output logic       warn_light,
    output logic       motor_down,
    output logic       motor_up,
    output logic       gate_open,
    output logic       fault,
    output logic [2:0] state,
    output logic [7:0] close_count
);

    localparam logic [2:0] S_OPEN    = 3'd0;
    localparam logic [2:0] S_WARN    = 3'd1;
    localparam logic [2:0] S_CLOSING = 3'd2;
    localparam logic [2:0] S_CLOSED  = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;
    localparam logic [2:0] S_OPENING = 3'd5;
    localparam logic [2:0] S_FAULT   = 3'd6;

    localparam logic [TW-1:0] WARN_LAST  = TW'(WARN_CYC - 1);
    localparam logic [TW-1:0] CLEAR_LAST = TW'(CLEAR_CYC - 1);
    localparam logic [TW-1:0] MOVE_LAST  = TW'(MOVE_TMO - 1);

    logic [2:0]    r_state;
    logic [2:0]    w_nextState;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_closeCount;
    logic          w_any;
    logic          w_conflict;
    logic          w_closeDone;

    assign w_any      = |occ;
    assign w_conflict = limit_closed & limit_open;

    // Sensor conflict outranks everything while moving; reversal outranks reaching the open limit.
    always_comb begin
        w_nextState = r_state;
        w_closeDone = 1'b0;
        case (r_state)
            S_OPEN: begin
                if (w_any) w_nextState = S_WARN;
            end
            S_WARN: begin
                if (r_timer == WARN_LAST) w_nextState = S_CLOSING;
            end
            S_CLOSING: begin
                if (w_conflict) begin
                    w_nextState = S_FAULT;
                end else if (limit_closed) begin
                    w_nextState = S_CLOSED;
                    w_closeDone = 1'b1;
                end else if (r_timer == MOVE_LAST) begin
                    w_nextState = S_FAULT;
                end
            end
            S_CLOSED: begin
                if (!w_any) w_nextState = S_HOLD;
            end
            S_HOLD: begin
                if (w_any) w_nextState = S_CLOSED;
                else if (r_timer == CLEAR_LAST) w_nextState = S_OPENING;
            end
            S_OPENING: begin
                if (w_conflict) w_nextState = S_FAULT;
                else if (w_any) w_nextState = S_CLOSING;
                else if (limit_open) w_nextState = S_OPEN;
                else if (r_timer == MOVE_LAST) w_nextState = S_FAULT;
            end
            S_FAULT: begin
                if (fault_clr) w_nextState = w_any ? S_CLOSING : S_OPENING;
            end
            default: w_nextState = S_FAULT;
        endcase
    end

    // The timer restarts on any state change, so "timer == N-1" means N cycles spent in the state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= S_OPEN;
            r_timer      <= '0;
            r_closeCount <= 8'd0;
        end else begin
            r_state <= w_nextState;
            if (w_nextState != r_state) r_timer <= '0;
            else                        r_timer <= r_timer + 1'b1;
            if (w_closeDone) r_closeCount <= r_closeCount + 8'd1;
        end
    end

    assign state       = r_state;
    assign close_count = r_closeCount;
    assign gate_open   = (r_state == S_OPEN);
    assign warn_light  = (r_state != S_OPEN);
    assign motor_down  = (r_state == S_CLOSING);
    assign motor_up    = (r_state == S_OPENING);
    assign fault       = (r_state == S_FAULT);

endmodule

// File: tb/tb_crossing_gate_sequencer.sv
// Directed testbench for crossing_gate_sequencer: each task drives one scenario and checks
// state, outputs and closure count against hand-computed values.
`timescale 1ns/1ps
module tb_crossing_gate_sequencer;

    localparam logic [2:0] S_OPEN    = 3'd0;
    localparam logic [2:0] S_WARN    = 3'd1;
    localparam logic [2:0] S_CLOSING = 3'd2;
    localparam logic [2:0] S_CLOSED  = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;
    localparam logic [2:0] S_OPENING = 3'd5;
    localparam logic [2:0] S_FAULT   = 3'd6;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [1:0] occ = 2'b00;
    logic       limit_closed = 1'b0;
    logic       limit_open = 1'b0;
    logic       fault_clr = 1'b0;
    logic       warn_light, motor_down, motor_up, gate_open, fault;
    logic [2:0] state;
    logic [7:0] close_count;

    int         nAssert = 0;
    int         nFail = 0;
    logic [7:0] expCount = 8'd0;

    crossing_gate_sequencer dut (
        .Clk(Clk), .Reset(Reset), .occ(occ),
        .limit_closed(limit_closed), .limit_open(limit_open), .fault_clr(fault_clr),
        .warn_light(warn_light), .motor_down(motor_down), .motor_up(motor_up),
        .gate_open(gate_open), .fault(fault), .state(state), .close_count(close_count)
    );

    always #5 Clk = ~Clk;

    // One clock edge, then settle so outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Drive from OPEN into CLOSED with occupancy already dropped.
    task automatic goToClosed();
        occ = 2'b01;
        step();
        occ = 2'b00;
        repeat (8) step();
        limit_closed = 1'b1;
        step();
        limit_closed = 1'b0;
        expCount = expCount + 8'd1;
    endtask

    // From CLOSED with tracks clear: one edge to HOLD, four HOLD cycles to OPENING.
    task automatic goToOpening();
        occ = 2'b00;
        repeat (5) step();
    endtask

    task automatic finishOpen();
        limit_open = 1'b1;
        step();
        limit_open = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        nAssert++;
        if (state !== S_OPEN || gate_open !== 1'b1 || warn_light !== 1'b0 || motor_down !== 1'b0 ||
            motor_up !== 1'b0 || fault !== 1'b0 || close_count !== 8'd0) begin
            nFail++;
            $display("[TB] FAIL reset_values: state=%0d go=%b wl=%b md=%b mu=%b f=%b cnt=%0d, required state=0 go=1 others 0",
                     state, gate_open, warn_light, motor_down, motor_up, fault, close_count);
        end
        Reset = 1'b0;
        step();
        nAssert++;
        if (state !== S_OPEN || gate_open !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL idle_after_reset: state=%0d go=%b, required 0/1", state, gate_open);
        end
    endtask

    task automatic test_nominal();
        occ = 2'b01;
        step();
        occ = 2'b00;
        for (int i = 0; i < 8; i++) begin
            nAssert++;
            if (state !== S_WARN || warn_light !== 1'b1 || gate_open !== 1'b0) begin
                nFail++;
                $display("[TB] FAIL nominal_warn[%0d]: state=%0d wl=%b go=%b, required 1/1/0", i, state, warn_light, gate_open);
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            nAssert++;
            if (state !== S_CLOSING || motor_down !== 1'b1 || motor_up !== 1'b0) begin
                nFail++;
                $display("[TB] FAIL nominal_closing[%0d]: state=%0d md=%b mu=%b, required 2/1/0", i, state, motor_down, motor_up);
            end
            step();
        end
        limit_closed = 1'b1;
        nAssert++;
        if (state !== S_CLOSING) begin
            nFail++;
            $display("[TB] FAIL nominal_closing_3: state=%0d, required 2", state);
        end
        step();
        limit_closed = 1'b0;
        expCount = expCount + 8'd1;
        nAssert++;
        if (state !== S_CLOSED || close_count !== expCount || motor_down !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL nominal_closed: state=%0d cnt=%0d md=%b, required 3/%0d/0", state, close_count, motor_down, expCount);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            nAssert++;
            if (state !== S_HOLD || motor_up !== 1'b0) begin
                nFail++;
                $display("[TB] FAIL nominal_hold[%0d]: state=%0d mu=%b, required 4/0", i, state, motor_up);
            end
            step();
        end
        nAssert++;
        if (state !== S_OPENING || motor_up !== 1'b1 || motor_down !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL nominal_opening: state=%0d mu=%b md=%b, required 5/1/0", state, motor_up, motor_down);
        end
        step();
        limit_open = 1'b1;
        step();
        limit_open = 1'b0;
        nAssert++;
        if (state !== S_OPEN || gate_open !== 1'b1 || warn_light !== 1'b0 || close_count !== expCount) begin
            nFail++;
            $display("[TB] FAIL nominal_reopen: state=%0d go=%b wl=%b cnt=%0d, required 0/1/0/%0d",
                     state, gate_open, warn_light, close_count, expCount);
        end
    endtask

    task automatic test_reoccupancy();
        goToClosed();
        step();
        step();
        occ = 2'b10;
        step();
        nAssert++;
        if (state !== S_CLOSED) begin
            nFail++;
            $display("[TB] FAIL reocc_back_to_closed: state=%0d, required 3", state);
        end
        occ = 2'b00;
        step();
        for (int i = 0; i < 4; i++) begin
            nAssert++;
            if (state !== S_HOLD) begin
                nFail++;
                $display("[TB] FAIL reocc_fresh_hold[%0d]: state=%0d, required 4", i, state);
            end
            step();
        end
        nAssert++;
        if (state !== S_OPENING) begin
            nFail++;
            $display("[TB] FAIL reocc_opening: state=%0d, required 5", state);
        end
        finishOpen();
    endtask

    task automatic test_reversal();
        goToClosed();
        goToOpening();
        occ = 2'b01;
        step();
        nAssert++;
        if (state !== S_CLOSING || motor_up !== 1'b0 || motor_down !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL reversal_closing: state=%0d mu=%b md=%b, required 2/0/1", state, motor_up, motor_down);
        end
        limit_closed = 1'b1;
        step();
        limit_closed = 1'b0;
        expCount = expCount + 8'd1;
        nAssert++;
        if (state !== S_CLOSED || close_count !== expCount) begin
            nFail++;
            $display("[TB] FAIL reversal_count: state=%0d cnt=%0d, required 3/%0d", state, close_count, expCount);
        end
        goToOpening();
        finishOpen();
    endtask

    task automatic test_close_timeout();
        occ = 2'b01;
        step();
        occ = 2'b00;
        repeat (8) step();
        for (int i = 0; i < 16; i++) begin
            nAssert++;
            if (state !== S_CLOSING) begin
                nFail++;
                $display("[TB] FAIL timeout_closing[%0d]: state=%0d, required 2", i, state);
            end
            step();
        end
        nAssert++;
        if (state !== S_FAULT || fault !== 1'b1 || motor_down !== 1'b0 || motor_up !== 1'b0 ||
            gate_open !== 1'b0 || warn_light !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL timeout_fault: state=%0d f=%b md=%b mu=%b go=%b wl=%b, required 6/1/0/0/0/1",
                     state, fault, motor_down, motor_up, gate_open, warn_light);
        end
        step();
        nAssert++;
        if (state !== S_FAULT) begin
            nFail++;
            $display("[TB] FAIL fault_holds: state=%0d, required 6", state);
        end
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        nAssert++;
        if (state !== S_OPENING || fault !== 1'b0 || close_count !== expCount) begin
            nFail++;
            $display("[TB] FAIL fault_clear_opening: state=%0d f=%b cnt=%0d, required 5/0/%0d", state, fault, close_count, expCount);
        end
        finishOpen();
    endtask

    task automatic test_conflict_and_reset();
        occ = 2'b01;
        step();
        occ = 2'b00;
        repeat (8) step();
        limit_closed = 1'b1;
        limit_open = 1'b1;
        step();
        limit_closed = 1'b0;
        limit_open = 1'b0;
        nAssert++;
        if (state !== S_FAULT || close_count !== expCount) begin
            nFail++;
            $display("[TB] FAIL sensor_conflict: state=%0d cnt=%0d, required 6/%0d", state, close_count, expCount);
        end
        #2;
        Reset = 1'b1;
        #0.5;
        expCount = 8'd0;
        nAssert++;
        if (state !== S_OPEN || gate_open !== 1'b1 || fault !== 1'b0 || warn_light !== 1'b0 ||
            motor_down !== 1'b0 || motor_up !== 1'b0 || close_count !== 8'd0) begin
            nFail++;
            $display("[TB] FAIL async_reset: state=%0d go=%b f=%b wl=%b md=%b mu=%b cnt=%0d, required 0/1/0/0/0/0/0",
                     state, gate_open, fault, warn_light, motor_down, motor_up, close_count);
        end
        #0.5;
        Reset = 1'b0;
        step();
    endtask

    task automatic test_counter_wrap();
        for (int i = 0; i < 255; i++) begin
            goToClosed();
            goToOpening();
            finishOpen();
        end
        nAssert++;
        if (close_count !== 8'd255 || state !== S_OPEN) begin
            nFail++;
            $display("[TB] FAIL count_255: cnt=%0d state=%0d, required 255/0", close_count, state);
        end
        goToClosed();
        nAssert++;
        if (close_count !== 8'd0 || expCount !== 8'd0) begin
            nFail++;
            $display("[TB] FAIL count_wrap: cnt=%0d, required 0", close_count);
        end
        goToOpening();
        finishOpen();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_reoccupancy();
        test_reversal();
        test_close_timeout();
        test_conflict_and_reset();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/crossing_gate_sequencer.md
Name: crossing_gate_sequencer

Overview:
- Moore FSM that sequences the physical barrier of the level crossing from the two per-track occupancy flags produced by the direction and wagon-count logic.
- Drives the warning light and the up/down motor commands, supervises the gate limit switches with a motion timeout, and delays reopening until both tracks have been clear for a programmable time.
- Sits between the track detection datapath and the gate actuator. Its gate_open output replaces the raw open flag at the top level.

Parameters:
WARN_CYC, 8, cycles of warning light before the gate starts to lower (>=1)
CLEAR_CYC, 4, consecutive cycles with both tracks clear before the gate starts to raise (>=1)
MOVE_TMO, 16, maximum cycles allowed for a lower or raise movement before a fault (>=1)
TW, 8, width of the internal cycle timer (must hold max of the three above)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
occ  input  2  occ[0] = track 1 occupied, occ[1] = track 2 occupied (levels)
limit_closed  input  1  gate fully-down switch
limit_open  input  1  gate fully-up switch
fault_clr  input  1  operator fault acknowledge (level, sampled)
warn_light  output  1  flashing-light enable
motor_down  output  1  lower-gate command
motor_up  output  1  raise-gate command
gate_open  output  1  1 only when the gate is confirmed up and idle
fault  output  1  fault indication
state  output  3  current state code
close_count  output  8  number of completed closures, wraps 255->0

Behaviour:
- Clock and reset: one clock domain, Clk. Reset is asynchronous and active-high.
- Reset values: state=OPEN, timer=0, close_count=0, gate_open=1, warn_light=0, motor_down=0, motor_up=0, fault=0. Reset asserted mid-motion aborts immediately to these values.
- Output timing: all outputs are decoded from the registered state, so there is no combinational path from inputs to outputs. An input change sampled at edge k is visible on the outputs after edge k.
- Timer: cleared on every state change, increments each cycle while the state is held. "Timer == N-1" means N cycles have been spent in the state.
- Any = |occ.
- States and codes:
  - OPEN (0): gate_open=1. If Any, go to WARN.
  - WARN (1): warn_light=1. When timer==WARN_CYC-1, go to CLOSING. Occupancy dropping does not abort the sequence.
  - CLOSING (2): warn_light=1, motor_down=1.
    - If limit_closed, go to CLOSED and increment close_count.
    - Else if timer==MOVE_TMO-1, go to FAULT.
  - CLOSED (3): warn_light=1. If !Any, go to HOLD.
  - HOLD (4): warn_light=1.
    - If Any, go back to CLOSED.
    - Else if timer==CLEAR_CYC-1, go to OPENING.
  - OPENING (5): warn_light=1, motor_up=1.
    - If Any, go to CLOSING (reversal; timer restarts; close_count increments again on the next limit_closed).
    - Else if limit_open, go to OPEN.
    - Else if timer==MOVE_TMO-1, go to FAULT.
  - FAULT (6): warn_light=1, fault=1, both motors 0, gate_open=0.
    - If fault_clr and Any, go to CLOSING.
    - If fault_clr and !Any, go to OPENING.
  - Code 7 is illegal; it recovers to FAULT on the next edge.
- Priority in CLOSING and OPENING, highest first:
  1. limit_closed && limit_open together: go to FAULT (inconsistent sensors).
  2. Occupancy reversal (OPENING only).
  3. Limit reached.
  4. Timeout.
- motor_down and motor_up are never both 1. gate_open is 0 in every state except OPEN.
- Limit switches are ignored in OPEN, WARN, CLOSED and HOLD.
- close_count is an 8-bit modulo counter.

Test Plan (defaults):
- Nominal cycle:
  - Stimulus: occ=01 for one cycle from OPEN; limit_closed at 3 cycles into CLOSING; occ=00; limit_open at 2 cycles into OPENING.
  - Required response: state path OPEN, WARN (exactly 8 cycles), CLOSING, CLOSED, HOLD (exactly 4 cycles), OPENING, OPEN.
  - Required response: close_count=1, gate_open back to 1, motors never both high.
- Re-occupancy during clear delay:
  - Stimulus: occ=00 then occ=10 at HOLD cycle 2.
  - Required response: return to CLOSED; HOLD then needs a fresh 4 clear cycles before OPENING.
- Reversal:
  - Stimulus: occ=01 while in OPENING.
  - Required response: CLOSING on the next edge, motor_up falls, motor_down rises; close_count=2 after limit_closed.
- Close timeout:
  - Stimulus: limit_closed held 0.
  - Required response: FAULT after exactly 16 CLOSING cycles, fault=1, motors 0.
  - Stimulus: fault_clr with occ=00.
  - Required response: OPENING.
- Sensor conflict and async reset:
  - Stimulus: limit_open=limit_closed=1 during CLOSING.
  - Required response: FAULT.
  - Stimulus: 1 ns Reset pulse between clock edges.
  - Required response: outputs return to reset values immediately, without waiting for a clock edge.
- Counter wrap:
  - Stimulus: 256 complete closure cycles.
  - Required response: close_count reads 0 after the 256th closure.
